// File: rtl/alu_pkg.sv
// Shared EX-stage ALU definitions: control encodings, MUL opcode and
// the multiply sequencer state type.
package alu_pkg;

  localparam logic [2:0]  ALU_PASS = 3'b000;
  localparam logic [2:0]  ALU_ADD  = 3'b010;
  localparam logic [2:0]  ALU_SUB  = 3'b011;

  localparam logic [10:0] OPC_MUL  = 11'b10011011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL controller: borrows the shared EX-stage ALU for one
// ADD per multiplier bit while stalling the pipeline, then returns the low half.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_own,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_cntrl,
  output logic              pipe_stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Early exit once no set multiplier bits remain keeps latency at N cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (op_a == '0 || op_b == '0) ? DONE : RUN;
      end
      RUN: begin
        if ((mplier >> 1) == '0 || cnt == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cntrl = ALU_PASS;
    busy      = 1'b0;
    done      = 1'b0;
    if (state_q == RUN) begin
      alu_own   = 1'b1;
      alu_a     = acc;
      alu_b     = mcand;
      alu_cntrl = ALU_ADD;
      busy      = 1'b1;
    end
    if (state_q == DONE) done = 1'b1;
  end

  assign pipe_stall = (state_q == IDLE && start) || state_q == RUN;

  // acc only changes on an accepted start or in RUN, so it doubles as the held result.
  assign result = acc;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

- Iterative shift-add controller for the 64-bit MUL instruction (low 64 bits of the product). It lives in the EX stage.
- While a multiply runs, it takes ownership of the shared EX-stage ALU for repeated ADD operations and stalls the rest of the pipeline.
- When the multiply finishes, it hands the ALU back and presents the product for the EX/MEM register.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- CNT_W, 7, iteration counter width; must hold DATA_W

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock, all state in clk domain
- start  in  1  single-cycle request; MUL decoded in EX with operands valid
- op_a  in  DATA_W  multiplicand (Rn value after forwarding)
- op_b  in  DATA_W  multiplier (Rm value after forwarding)
- alu_result  in  DATA_W  shared ALU output
- alu_own  out  1  1 = sequencer drives ALU operand muxes and control
- alu_a  out  DATA_W  ALU operand A when alu_own
- alu_b  out  DATA_W  ALU operand B when alu_own
- alu_cntrl  out  3  3'b010 (ADD) when alu_own, else 3'b000
- pipe_stall  out  1  freezes PC, IF/ID, ID/EX; bubbles EX/MEM
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse, result valid
- result  out  DATA_W  product low half; held until next start

## Operation
- State IDLE:
  - On start, latch mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0.
  - If op_a==0 or op_b==0, go to DONE. Else go to RUN.
- State RUN, every cycle:
  - alu_own=1, alu_a=acc, alu_b=mcand.
  - If mplier[0], acc<=alu_result. Else acc is held.
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Go to DONE when the shifted mplier is 0 or cnt==DATA_W-1. Else stay in RUN.
- State DONE:
  - done=1 and result=acc. Go to IDLE.
- Outputs when not in RUN: alu_own=0, alu_a=0, alu_b=0.
- Arithmetic:
  - Modulo 2^DATA_W. Overflow is discarded.
  - Signed and unsigned give identical low halves, so there is no sign handling.
- start while not IDLE is ignored. No queueing, no error.
- start and reset in the same cycle: reset wins.
- A second start in the cycle immediately after DONE is accepted normally.
- Reset mid-RUN or in DONE:
  - Next cycle is IDLE, with all outputs and internal registers at 0.
  - No done pulse.

## Timing
- Reset values:
  - alu_own=0, alu_a=0, alu_b=0, alu_cntrl=3'b000.
  - pipe_stall=0, busy=0, done=0, result=0, state=IDLE.
- pipe_stall is combinational: (state==IDLE && start) || state==RUN.
  - It is asserted in the start cycle T so ID/IF hold.
  - It is deasserted in DONE so the pipeline advances with result.
- Let N = index of the most significant set bit of op_b, plus 1.
  - Zero operand: DONE at T+1.
  - Otherwise: RUN for cycles T+1..T+N, DONE at T+N+1.
  - Maximum latency: DONE at T+65 (op_b[63]=1).
- alu_result is sampled in the same cycle alu_a/alu_b are driven. ALU is combinational, single-cycle path.
- result is registered. It is stable from the DONE cycle until the next accepted start.

## Structure
- Shared package (alu_pkg) holds:
  - ALU control constants: ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_PASS=3'b000.
  - MUL opcode constant 11'b10011011000.
  - Sequencer state enum: IDLE, RUN, DONE.
- No sub-module.
- One module with:
  - State register.
  - Three shift/accumulate registers.
  - Counter.
  - Combinational output block.
- EX-stage mux selecting sequencer vs decoder ALU controls on alu_own lives in the EX stage top, not here.

## Test plan
- op_a=3, op_b=5, start at T:
  - pipe_stall=1 at T.
  - busy T+1..T+3.
  - done at T+4, result=15.
  - alu_cntrl=3'b010 only during RUN.
- op_a=0x1234, op_b=0:
  - done at T+1, result=0.
  - alu_own never asserted.
- op_a=all-ones, op_b=2:
  - 2 RUN cycles, done at T+3.
  - result=0xFFFF_FFFF_FFFF_FFFE.
- op_a=3, op_b=1<<63:
  - 64 RUN cycles, done at T+65.
  - result=0x8000_0000_0000_0000.
- start pulsed again at T+2 during op_b=0xFF run:
  - Ignored; original result=255*op_a delivered at T+9.
  - A start at the DONE+1 cycle is accepted.
- reset asserted at T+3 of an op_b=0xF0 run:
  - IDLE at T+4 with all outputs 0 and no done pulse.
  - A fresh start then completes correctly.
